// File: rtl/dmem_pipelined_if.sv
// Request/response bundle between the LSU/MEM stage and the data memory.
// Master (requester) drives req_*; slave (memory) drives req_ready, rsp_* and busy.
// Ports: req_valid/req_ready handshake, req_we/req_funct3/req_addr/req_wdata, rsp_valid/rsp_rdata/rsp_err, busy.
interface dmem_pipelined_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic            busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_pipelined.sv
// Byte-addressed RV32/RV64 data memory: funct3 decode, load extension, post-reset clear sweep, error flagging.
// Latency: response exactly RD_LAT cycles after accept; back-to-back accepts give back-to-back in-order responses.
// Backpressure: req_ready low only while the array is being cleared after reset; no response backpressure.
// Ports: clk, reset (async active-low), bus (slave modport: req_* in, req_ready/rsp_*/busy out).
// Build option: DMEM_MISALIGN_TRAP_EN defined -> misaligned access is an error; undefined -> low offset bits are dropped.
module dmem_pipelined #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    dmem_pipelined_if.slave  bus
);
    localparam int NB = XLEN / 8;
    localparam int B  = $clog2(NB);
    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]      state;
    logic [AW-1:0]   clr_cnt;
    logic [XLEN-1:0] mem [DEPTH];

    logic            acc;
    logic [1:0]      size;
    logic            uns;
    logic            f3_ok;
    logic            acc_err;
    logic [B-1:0]    off_raw;
    logic [B-1:0]    align_mask;
    logic [B-1:0]    off;
    logic [AW-1:0]   word_idx;
    logic [7:0]      lanes8;
    logic [NB-1:0]   wr_lanes;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rd_sh;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] rsp_dat_in;

    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_err;
    logic [XLEN-1:0]   pipe_dat [RD_LAT];

    // Address bits above the word index wrap the array; tie them off explicitly.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[XLEN-1:B+AW];

    assign bus.req_ready = (state == ST_RUN);
    assign acc           = bus.req_valid & bus.req_ready;

    assign size     = bus.req_funct3[1:0];
    assign uns      = bus.req_funct3[2];
    assign off_raw  = bus.req_addr[B-1:0];
    assign word_idx = bus.req_addr[B +: AW];

    always_comb begin
        f3_ok = 1'b0;
        if (bus.req_we) begin
            f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010) ||
                    ((XLEN == 64) && (bus.req_funct3 == 3'b011));
        end else begin
            f3_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                    (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                    (bus.req_funct3 == 3'b101) ||
                    ((XLEN == 64) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)));
        end
    end

    // Offset bits that must be zero for a naturally aligned access of this size.
    always_comb begin
        align_mask = '0;
        lanes8     = 8'h01;
        case (size)
            2'd0: begin align_mask = '0;       lanes8 = 8'h01; end
            2'd1: begin align_mask = B'(1);    lanes8 = 8'h03; end
            2'd2: begin align_mask = B'(3);    lanes8 = 8'h0F; end
            default: begin align_mask = B'(7); lanes8 = 8'hFF; end
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    assign mis     = |(off_raw & align_mask);
    assign off     = off_raw;
    assign acc_err = ~f3_ok | mis;
`else
    // Misaligned offsets are rounded down to the access size instead of trapping.
    assign off     = off_raw & ~align_mask;
    assign acc_err = ~f3_ok;
`endif

    assign wr_lanes = NB'(lanes8) << off;
    assign wdata_sh = bus.req_wdata << {off, 3'b000};

    // Read happens before this edge's write, so a store is visible to the next cycle's load.
    assign rd_sh = mem[word_idx] >> {off, 3'b000};

    always_comb begin
        ld_data = '0;
        case (size)
            2'd0: ld_data = uns ? XLEN'(rd_sh[7:0])  : XLEN'($signed(rd_sh[7:0]));
            2'd1: ld_data = uns ? XLEN'(rd_sh[15:0]) : XLEN'($signed(rd_sh[15:0]));
            2'd2: ld_data = uns ? XLEN'(rd_sh[31:0]) : XLEN'($signed(rd_sh[31:0]));
            default: ld_data = rd_sh;
        endcase
    end

    assign rsp_dat_in = (acc && !bus.req_we && !acc_err) ? ld_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            clr_cnt  <= '0;
            pipe_vld <= '0;
            pipe_err <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            if (state == ST_INIT) begin
                clr_cnt <= clr_cnt + 1'b1;
                if (clr_cnt == AW'(DEPTH - 1)) begin
                    state <= ST_RUN;
                end
            end
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_err[i] <= pipe_err[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
            pipe_vld[0] <= acc;
            pipe_err[0] <= acc & acc_err;
            pipe_dat[0] <= rsp_dat_in;
        end
    end

    // Array has no reset; the INIT sweep clears it after every reset.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (acc && bus.req_we && !acc_err) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_lanes[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign bus.rsp_valid = pipe_vld[RD_LAT-1];
    assign bus.rsp_err   = pipe_err[RD_LAT-1];
    assign bus.rsp_rdata = pipe_dat[RD_LAT-1];
    assign bus.busy      = (state == ST_INIT) | (|pipe_vld);
endmodule
